bluetooth_decoder: RTL and testbench



---
 rtl/bt_ascii_pkg.sv | 27 ++
 rtl/bt_keyword_matcher.sv | 54 +++++
 rtl/bluetooth_decoder.sv | 147 ++++++++++++++
 tb/tb_bluetooth_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_ascii_pkg.sv
// ASCII constants, keyword byte arrays and FSM state type shared by the BLE line decoder and encoder.
package bt_ascii_pkg;

    localparam int MAX_BYTES = 4;

    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_K    = 8'h4B;
    localparam logic [7:0] ASCII_O    = 8'h4F;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_T    = 8'h54;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Keywords are stored first character in the most significant element.
    localparam logic [1:0][7:0] KW_OK    = {ASCII_O, ASCII_K};
    localparam logic [4:0][7:0] KW_ERROR = {ASCII_E, ASCII_R, ASCII_R, ASCII_O, ASCII_R};
    localparam logic [2:0][7:0] KW_AT    = {ASCII_A, ASCII_T, ASCII_PLUS};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LINE = 2'd1,
        ST_HOLD = 2'd2
    } dec_state_e;

endpackage

// File: rtl/bt_keyword_matcher.sv
// Incremental keyword matcher: tracks whether the bytes of the current line equal KEYWORD.
// EXACT=1 demands the line length equal KW_LEN; EXACT=0 accepts KEYWORD as a prefix.
module bt_keyword_matcher #(
    parameter int                      KW_LEN  = 2,
    parameter logic [KW_LEN-1:0][7:0]  KEYWORD = '0,
    parameter bit                      EXACT   = 1'b1,
    parameter int                      LEN_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic [LEN_W-1:0] idx,
    input  logic             accept,
    input  logic             clear,
    output logic             hit
);

    logic match_q, match_d;
    logic full_q, full_d;

    always_comb begin
        match_d = match_q;
        full_d  = full_q;
        if (clear) begin
            match_d = 1'b1;
            full_d  = 1'b0;
        end else if (accept) begin
            if (idx < LEN_W'(KW_LEN)) begin
                for (int i = 0; i < KW_LEN; i++) begin
                    if (idx == LEN_W'(i)) begin
                        match_d = match_q && (byte_in == KEYWORD[KW_LEN-1-i]);
                    end
                end
                full_d = (idx == LEN_W'(KW_LEN - 1));
            end else if (EXACT) begin
                // A byte past the keyword length rules out an exact match.
                full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            match_q <= match_d;
            full_q  <= full_d;
        end
    end

    assign hit = match_q && full_q;

endmodule

// File: rtl/bluetooth_decoder.sv
// BLE UART receive decoder: splits LF-terminated lines into OK/ERROR pulses or packed 32-bit payloads.
// Define BT_DECODER_ECHO_FILTER_EN to silently drop "AT+" command-echo lines.
module bluetooth_decoder
    import bt_ascii_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] data_out,
    output logic [2:0]  data_len,
    output logic        data_trunc,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        status_ok,
    output logic        status_err
);

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    dec_state_e       state_q, state_d;
    logic [LEN_W-1:0] line_len_q, line_len_d;
    logic [31:0]      lanes_q, lanes_d;
    logic             trunc_q, trunc_d;
    logic [31:0]      data_out_q, data_out_d;
    logic [2:0]       data_len_q, data_len_d;
    logic             data_trunc_q, data_trunc_d;
    logic             status_ok_q, status_ok_d;
    logic             status_err_q, status_err_d;

    logic accept, byte_acc, line_end;
    logic ok_hit, err_hit, drop_line;

    assign rx_ready = (state_q != ST_HOLD);
    assign accept   = rx_valid && rx_ready;
    assign byte_acc = accept && (rx_byte != ASCII_CR) && (rx_byte != ASCII_LF);
    assign line_end = accept && (rx_byte == ASCII_LF);

    bt_keyword_matcher #(.KW_LEN(2), .KEYWORD(KW_OK), .EXACT(1'b1), .LEN_W(LEN_W)) u_match_ok (
        .clk(clk), .reset(reset), .byte_in(rx_byte), .idx(line_len_q),
        .accept(byte_acc), .clear(line_end), .hit(ok_hit)
    );

    bt_keyword_matcher #(.KW_LEN(5), .KEYWORD(KW_ERROR), .EXACT(1'b1), .LEN_W(LEN_W)) u_match_err (
        .clk(clk), .reset(reset), .byte_in(rx_byte), .idx(line_len_q),
        .accept(byte_acc), .clear(line_end), .hit(err_hit)
    );

`ifdef BT_DECODER_ECHO_FILTER_EN
    bt_keyword_matcher #(.KW_LEN(3), .KEYWORD(KW_AT), .EXACT(1'b0), .LEN_W(LEN_W)) u_match_echo (
        .clk(clk), .reset(reset), .byte_in(rx_byte), .idx(line_len_q),
        .accept(byte_acc), .clear(line_end), .hit(drop_line)
    );
`else
    assign drop_line = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        line_len_d   = line_len_q;
        lanes_d      = lanes_q;
        trunc_d      = trunc_q;
        data_out_d   = data_out_q;
        data_len_d   = data_len_q;
        data_trunc_d = data_trunc_q;
        status_ok_d  = 1'b0;
        status_err_d = 1'b0;

        if (state_q == ST_HOLD) begin
            if (data_ready) begin
                state_d = ST_IDLE;
            end
        end else begin
            if (byte_acc) begin
                state_d = ST_LINE;
                if (line_len_q < LEN_W'(MAX_BYTES)) begin
                    case (line_len_q[1:0])
                        2'd0:    lanes_d[31:24] = rx_byte;
                        2'd1:    lanes_d[23:16] = rx_byte;
                        2'd2:    lanes_d[15:8]  = rx_byte;
                        default: lanes_d[7:0]   = rx_byte;
                    endcase
                end else begin
                    trunc_d = 1'b1;
                end
                if (line_len_q != LEN_MAX) begin
                    line_len_d = line_len_q + 1'b1;
                end
            end

            // Every LF wipes the line state; only non-keyword, non-empty lines become payload.
            if (line_end) begin
                state_d    = ST_IDLE;
                line_len_d = '0;
                lanes_d    = '0;
                trunc_d    = 1'b0;
                if ((line_len_q != '0) && !drop_line) begin
                    if (ok_hit) begin
                        status_ok_d = 1'b1;
                    end else if (err_hit) begin
                        status_err_d = 1'b1;
                    end else begin
                        data_out_d   = lanes_q;
                        data_len_d   = (line_len_q >= LEN_W'(MAX_BYTES)) ? 3'(MAX_BYTES) : line_len_q[2:0];
                        data_trunc_d = trunc_q;
                        state_d      = ST_HOLD;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            line_len_q   <= '0;
            lanes_q      <= '0;
            trunc_q      <= 1'b0;
            data_out_q   <= '0;
            data_len_q   <= '0;
            data_trunc_q <= 1'b0;
            status_ok_q  <= 1'b0;
            status_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_len_q   <= line_len_d;
            lanes_q      <= lanes_d;
            trunc_q      <= trunc_d;
            data_out_q   <= data_out_d;
            data_len_q   <= data_len_d;
            data_trunc_q <= data_trunc_d;
            status_ok_q  <= status_ok_d;
            status_err_q <= status_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_len   = data_len_q;
    assign data_trunc = data_trunc_q;
    assign data_valid = (state_q == ST_HOLD);
    assign status_ok  = status_ok_q;
    assign status_err = status_err_q;

endmodule

// File: tb/tb_bluetooth_decoder.sv
// Testbench for bluetooth_decoder: line-level reference model checked every cycle plus directed literal checks.
module tb_bluetooth_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] data_out;
    logic [2:0]  data_len;
    logic        data_trunc;
    logic        data_valid;
    logic        data_ready = 1'b1;
    logic        status_ok;
    logic        status_err;

    int n_checks = 0;
    int n_errors = 0;

    bluetooth_decoder dut (
        .clk(clk), .reset(reset),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .data_out(data_out), .data_len(data_len), .data_trunc(data_trunc),
        .data_valid(data_valid), .data_ready(data_ready),
        .status_ok(status_ok), .status_err(status_err)
    );

    always #5 clk = ~clk;

    // Reference model state: the whole current line as a byte queue, plus expected outputs.
    logic [7:0]  line_q[$];
    logic [31:0] m_out = '0;
    logic [2:0]  m_len = '0;
    logic        m_trunc = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_ok = 1'b0;
    logic        m_err = 1'b0;
    bit          model_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic classify_line();
        int n;
        n = line_q.size();
        if (n == 0) return;
        if (n == 2 && line_q[0] == 8'h4F && line_q[1] == 8'h4B) begin
            m_ok = 1'b1;
        end else if (n == 5 && line_q[0] == 8'h45 && line_q[1] == 8'h52 && line_q[2] == 8'h52
                     && line_q[3] == 8'h4F && line_q[4] == 8'h52) begin
            m_err = 1'b1;
`ifdef BT_DECODER_ECHO_FILTER_EN
        end else if (n >= 3 && line_q[0] == 8'h41 && line_q[1] == 8'h54 && line_q[2] == 8'h2B) begin
            m_ok = 1'b0;
`endif
        end else begin
            m_out = '0;
            for (int i = 0; i < 4 && i < n; i++) m_out[31-8*i -: 8] = line_q[i];
            m_len   = (n > 4) ? 3'd4 : 3'(n);
            m_trunc = (n > 4);
            m_valid = 1'b1;
        end
    endtask

    task automatic model_step();
        bit accepted;
        if (reset) begin
            line_q.delete();
            m_out = '0; m_len = '0; m_trunc = 1'b0; m_valid = 1'b0; m_ok = 1'b0; m_err = 1'b0;
            model_live = 1'b1;
            return;
        end
        m_ok  = 1'b0;
        m_err = 1'b0;
        accepted = rx_valid && !m_valid;
        if (m_valid && data_ready) m_valid = 1'b0;
        if (accepted) begin
            if (rx_byte == 8'h0A) begin
                classify_line();
                line_q.delete();
            end else if (rx_byte != 8'h0D) begin
                line_q.push_back(rx_byte);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        model_step();
        if (model_live) begin
            chk("cyc_rx_ready",   32'(rx_ready),   32'(!m_valid));
            chk("cyc_data_valid", 32'(data_valid), 32'(m_valid));
            chk("cyc_status_ok",  32'(status_ok),  32'(m_ok));
            chk("cyc_status_err", 32'(status_err), 32'(m_err));
            chk("cyc_data_out",   data_out,        m_out);
            chk("cyc_data_len",   32'(data_len),   32'(m_len));
            chk("cyc_data_trunc", 32'(data_trunc), 32'(m_trunc));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic r;
        rx_byte  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            r = rx_ready;
            @(negedge clk);
            if (r) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: byte %0h not accepted within 40 cycles", b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        rx_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_data_valid", 32'(data_valid), 32'd0);
        chk("reset_rx_ready",   32'(rx_ready),   32'd1);
        chk("reset_data_out",   data_out,        32'd0);
        chk("reset_status",     32'({status_ok, status_err}), 32'd0);
        reset = 1'b0;
        cycles(1);

        send_str("OK\r\n");
        chk("ok_pulse",      32'(status_ok),  32'd1);
        chk("ok_no_payload", 32'(data_valid), 32'd0);
        cycles(1);
        chk("ok_pulse_end",  32'(status_ok),  32'd0);

        send_str("ERROR\r\n");
        chk("err_pulse",     32'(status_err), 32'd1);
        cycles(1);
        chk("err_pulse_end", 32'(status_err), 32'd0);

        send_str("ERRORS\r\n");
        chk("errors_valid", 32'(data_valid), 32'd1);
        chk("errors_out",   data_out,        32'h4552524F);
        chk("errors_model", m_out,           32'h4552524F);
        chk("errors_len",   32'(data_len),   32'd4);
        chk("errors_trunc", 32'(data_trunc), 32'd1);
        cycles(1);

        data_ready = 1'b0;
        send_str("ABCD\r\n");
        rx_byte  = 8'h5A;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(data_valid), 32'd1);
            chk("hold_out",   data_out,        32'h41424344);
            chk("hold_len",   32'(data_len),   32'd4);
            chk("hold_trunc", 32'(data_trunc), 32'd0);
            chk("hold_ready", 32'(rx_ready),   32'd0);
            cycles(1);
        end
        rx_valid   = 1'b0;
        data_ready = 1'b1;
        cycles(1);
        chk("consume_valid", 32'(data_valid), 32'd0);
        chk("consume_ready", 32'(rx_ready),   32'd1);
        chk("consume_keep",  data_out,        32'h41424344);

        send_str("HI\n");
        chk("hi_out",   data_out,        32'h48490000);
        chk("hi_model", m_out,           32'h48490000);
        chk("hi_len",   32'(data_len),   32'd2);
        chk("hi_trunc", 32'(data_trunc), 32'd0);
        cycles(1);
        send_str("\r\n");
        chk("empty_quiet", 32'({data_valid, status_ok, status_err}), 32'd0);
        cycles(2);

        send_str("OKX\n");
        chk("okx_out", data_out,      32'h4F4B5800);
        chk("okx_len", 32'(data_len), 32'd3);
        chk("okx_not_ok", 32'(status_ok), 32'd0);
        cycles(1);

        send_str("0123456789ABCDEFGHIJ\n");
        chk("long_out",   data_out,        32'h30313233);
        chk("long_len",   32'(data_len),   32'd4);
        chk("long_trunc", 32'(data_trunc), 32'd1);
        cycles(1);

        send_str("ERR");
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        send_str("OK\r\n");
        chk("rst_mid_ok",  32'(status_ok),  32'd1);
        chk("rst_mid_err", 32'(status_err), 32'd0);
        chk("rst_mid_dv",  32'(data_valid), 32'd0);
        cycles(1);

        data_ready = 1'b0;
        send_str("XY\n");
        chk("rst_hold_valid", 32'(data_valid), 32'd1);
        reset = 1'b1;
        cycles(1);
        chk("rst_hold_drop",  32'(data_valid), 32'd0);
        chk("rst_hold_ready", 32'(rx_ready),   32'd1);
        reset = 1'b0;
        data_ready = 1'b1;
        cycles(2);

        send_str("AT+BLEUARTTX\r\n");
`ifdef BT_DECODER_ECHO_FILTER_EN
        chk("echo_dropped", 32'({data_valid, status_ok, status_err}), 32'd0);
`else
        chk("echo_out",   data_out,        32'h41542B42);
        chk("echo_len",   32'(data_len),   32'd4);
        chk("echo_trunc", 32'(data_trunc), 32'd1);
`endif
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
